multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Sequential main controller for the multi-cycle MIPS datapath. Successor to the single-cycle combinational ALU decoder.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives all datapath enables.
- Generates the ALU select internally from opcode and funct, with a parametrised select width.
- Memory accesses use a ready handshake with a bounded wait counter.

Parameters:
- ALU_SEL_W, 3: width of alu_sel. Must be >= 3; extra MSBs are driven 0.
- MAX_WAIT, 15: maximum cycles in any memory state without mem_ready before mem_timeout is flagged.
- WAIT_CNT_W, 4: width of the wait counter. Must hold MAX_WAIT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- opcode  in  6  instruction[31:26], valid from DECODE onward
- function_code  in  6  instruction[5:0]
- zero  in  1  ALU zero flag, sampled in EXEC for beq
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  instruction register load
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  0 = address from PC, 1 = address from ALUOut
- reg_write  out  1  register-file write enable
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_sel  out  ALU_SEL_W  ALU operation
- illegal_op  out  1  sticky; unsupported opcode/funct
- mem_timeout  out  1  sticky; wait counter reached MAX_WAIT
- state  out  4  current state encoding, for debug

Behaviour:
- Reset (async, rst=1):
  - state = FETCH (0).
  - All enables 0, alu_sel = 0, pc_src = 00, sticky flags cleared, wait counter = 0.
- Outputs are a Moore decode of state, plus opcode/funct where needed. No output depends on mem_ready except pc_write and ir_write in FETCH.
- ALU select codes: AND = 000, OR = 001, ADD = 010, SUB = 110, SLT = 111.
  - Memory and address states use ADD; beq uses SUB.
  - R-type funct decode: 100000 → ADD, 100010 → SUB, 100100 → AND, 100101 → OR, 101010 → SLT.
- FETCH (0):
  - Drives mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, ADD, pc_src = 00.
  - Holds while mem_ready = 0.
  - On mem_ready = 1: pc_write = ir_write = 1, then go to DECODE.
- DECODE (1):
  - Drives alu_src_a = 0, alu_src_b = 11, ADD (branch target into ALUOut).
  - Next state by opcode:
    - 100011 lw / 101011 sw → MEMADR
    - 000000 R-type → EXEC_R
    - 000100 beq → BRANCH
    - 001000 addi → EXEC_I
    - 000010 j → JUMP
    - any other opcode → set illegal_op, go to FETCH
- MEMADR (2): alu_src_a = 1, alu_src_b = 10, ADD. lw → MEMRD, sw → MEMWR.
- MEMRD (3): mem_read = 1, i_or_d = 1. Waits for mem_ready, then → MEM_WB.
- MEM_WB (4): reg_write = 1, mem_to_reg = 1, reg_dst = 0, then → FETCH.
- MEMWR (5): mem_write = 1, i_or_d = 1. Waits for mem_ready, then → FETCH.
- EXEC_R (6):
  - alu_src_a = 1, alu_src_b = 00, alu_sel from funct.
  - Unknown funct → set illegal_op, go to FETCH with no write.
  - Otherwise → R_WB.
- R_WB (7): reg_write = 1, reg_dst = 1, mem_to_reg = 0, then → FETCH.
- BRANCH (8): alu_src_a = 1, alu_src_b = 00, SUB, pc_src = 01, pc_write = zero, then → FETCH.
- EXEC_I (9): alu_src_a = 1, alu_src_b = 10, ADD, then → I_WB.
- I_WB (10): reg_write = 1, reg_dst = 0, mem_to_reg = 0, then → FETCH.
- JUMP (11): pc_src = 10, pc_write = 1, then → FETCH.
- Wait counter:
  - Counts each cycle spent in FETCH, MEMRD or MEMWR with mem_ready = 0.
  - Cleared on state exit.
  - Saturates at MAX_WAIT. On reaching it, mem_timeout is set.
  - The state keeps waiting; no abort.
- mem_ready = 1 on the first cycle of a memory state gives a 1-cycle access.
- Latency with zero wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- Unused encodings 12–15 → FETCH on the next edge, with illegal_op set.
- rst asserted mid-instruction: immediate return to FETCH. No partial write may be asserted in the reset cycle.

Optional Feature:
- Macro: CTRL_IMM_LOGIC_EN.
- When defined:
  - Opcodes 001100 andi and 001101 ori route to EXEC_I.
  - alu_sel is AND or OR respectively; the immediate is zero-extended (alu_src_b = 10 with a zext request bit).
  - Adds output zext  out  1, high in EXEC_I for andi/ori.
- When undefined: these opcodes set illegal_op, and the zext port is absent.

Test Plan:
- Reset mid-MEMRD: rst pulse → state = 0, all enables 0, flags 0 within the same cycle (async).
- lw with mem_ready stuck 0 for 3 cycles in MEMRD:
  - Sequence 0,1,2,3,3,3,3,4,0.
  - reg_write = 1 only in state 4; mem_timeout = 0.
- R-type funct 100010: EXEC_R shows alu_sel = 110, then R_WB shows reg_write = 1, reg_dst = 1. Total 4 cycles.
- beq: zero = 1 → pc_write = 1, pc_src = 01 in BRANCH; zero = 0 → pc_write = 0. Both return to FETCH.
- opcode 111111: illegal_op = 1 after DECODE, next state FETCH, no reg_write/mem_write; the flag stays set through the next instruction.
- mem_ready = 0 for 20 cycles in FETCH: mem_timeout rises after 15 wait cycles and remains 1; on mem_ready = 1 → DECODE.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main controller: Moore FSM with a memory-ready handshake and a bounded wait counter.
// Optional macro CTRL_IMM_LOGIC_EN adds andi/ori support and the zext output.
module multicycle_control_unit #(
    parameter int unsigned ALU_SEL_W  = 3,
    parameter int unsigned MAX_WAIT   = 15,
    parameter int unsigned WAIT_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           function_code,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 i_or_d,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_src,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 illegal_op,
    output logic                 mem_timeout,
`ifdef CTRL_IMM_LOGIC_EN
    output logic                 zext,
`endif
    output logic [3:0]           state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEM_WB = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_R_WB   = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_EXEC_I = 4'd9;
    localparam logic [3:0] S_I_WB   = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_IMM_LOGIC_EN
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MAX_WAIT);

    logic [3:0]            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic                  illegal_q, illegal_d;
    logic                  timeout_q, timeout_d;
    logic                  waiting;
    logic                  funct_ok;
    logic [2:0]            funct_sel;
    logic [2:0]            sel_c;

    always_comb begin
        funct_ok  = 1'b1;
        funct_sel = ALU_ADD;
        case (function_code)
            F_ADD:   funct_sel = ALU_ADD;
            F_SUB:   funct_sel = ALU_SUB;
            F_AND:   funct_sel = ALU_AND;
            F_OR:    funct_sel = ALU_OR;
            F_SLT:   funct_sel = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        waiting   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           waiting = 1'b1;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_EXEC_I;
`ifdef CTRL_IMM_LOGIC_EN
                    OP_ANDI, OP_ORI: state_d = S_EXEC_I;
`endif
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEM_WB;
                else           waiting = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
                else           waiting = 1'b1;
            end
            S_EXEC_R: begin
                if (funct_ok) begin
                    state_d = S_R_WB;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_MEM_WB, S_R_WB, S_BRANCH, S_I_WB, S_JUMP: state_d = S_FETCH;
            S_EXEC_I: state_d = S_I_WB;
            default: begin
                state_d   = S_FETCH;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Any cycle not spent stalled in a memory state clears the counter, which covers state exit.
    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        if (waiting) begin
            wait_d = (wait_q < WAIT_MAX) ? wait_q + 1'b1 : wait_q;
            if (wait_d == WAIT_MAX) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        sel_c      = ALU_AND;
`ifdef CTRL_IMM_LOGIC_EN
        zext       = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                sel_c     = ALU_ADD;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                sel_c     = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                sel_c     = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                sel_c    = ALU_ADD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                sel_c     = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                sel_c     = funct_sel;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                sel_c     = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = zero;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                sel_c     = ALU_ADD;
`ifdef CTRL_IMM_LOGIC_EN
                if (opcode == OP_ANDI) begin
                    sel_c = ALU_AND;
                    zext  = 1'b1;
                end else if (opcode == OP_ORI) begin
                    sel_c = ALU_OR;
                    zext  = 1'b1;
                end
`endif
            end
            S_I_WB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        // Reset forces every strobe low combinationally so nothing leaks out in the reset cycle.
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            sel_c      = ALU_AND;
`ifdef CTRL_IMM_LOGIC_EN
            zext       = 1'b0;
`endif
        end
    end

    assign alu_sel     = ALU_SEL_W'(sel_c);
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: instruction-level reference model with random stimulus.
module tb_multicycle_control_unit;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEM_WB = 4, S_MEMWR = 5;
    localparam int S_EXEC_R = 6, S_R_WB = 7, S_BRANCH = 8, S_EXEC_I = 9, S_I_WB = 10, S_JUMP = 11;
    localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_R = 3, K_BEQ = 4, K_ADDI = 5, K_J = 6, K_IMM = 7;
    localparam int MAXW = 15;
`ifdef CTRL_IMM_LOGIC_EN
    localparam logic [31:0] FULL_MASK = 32'h007F_FFFF;
`else
    localparam logic [31:0] FULL_MASK = 32'h003F_FFFF;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, function_code;
    logic       zero, mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_sel;
    logic       illegal_op, mem_timeout;
    logic [3:0] state;
`ifdef CTRL_IMM_LOGIC_EN
    logic       zext;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        exp_illegal, exp_timeout;
    int          wait_run;
    logic [31:0] rec[$];

    multicycle_control_unit #(.ALU_SEL_W(3), .MAX_WAIT(15), .WAIT_CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .function_code(function_code),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_sel(alu_sel), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
`ifdef CTRL_IMM_LOGIC_EN
        .zext(zext),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int op_kind(input logic [5:0] op);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
`ifdef CTRL_IMM_LOGIC_EN
            6'b001100, 6'b001101: return K_IMM;
`endif
            default:   return K_ILL;
        endcase
    endfunction

    // {legal, alu code} for an R-type funct
    function automatic logic [3:0] funct_map(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1_010;
            6'b100010: return 4'b1_110;
            6'b100100: return 4'b1_000;
            6'b100101: return 4'b1_001;
            6'b101010: return 4'b1_111;
            default:   return 4'b0_000;
        endcase
    endfunction

    function automatic logic [31:0] act_word();
        logic zx;
`ifdef CTRL_IMM_LOGIC_EN
        zx = zext;
`else
        zx = 1'b0;
`endif
        return {9'b0, zx, state, mem_timeout, illegal_op, alu_sel, pc_src, alu_src_b, alu_src_a,
                mem_to_reg, reg_dst, i_or_d, reg_write, mem_write, mem_read, ir_write, pc_write};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                         input logic [31:0] mask);
        n_checks++;
        if (((act ^ exp) & mask) === 32'h0) n_pass++;
        else $display("FAIL %s: got %h expected %h (mask %h)", name, act & mask, exp & mask, mask);
    endtask

    task automatic expect_word(input int st, input logic [5:0] op, input logic [5:0] fn,
                               input logic rdy, input logic zr,
                               output logic [31:0] e, output logic [31:0] m);
        logic pcw, irw, mr, mw, rw, iod, rd, m2r, sa, zx;
        logic [1:0] sb, ps;
        logic [2:0] sel;
        logic [3:0] fm;
        logic [3:0] st4;
        {pcw, irw, mr, mw, rw, iod, rd, m2r, sa, zx} = '0;
        sb  = 2'b00;
        ps  = 2'b00;
        sel = 3'b000;
        st4 = st[3:0];
        m   = FULL_MASK & ~32'h0000_FFE0;
        case (st)
            S_FETCH: begin
                mr = 1'b1; pcw = rdy; irw = rdy; sb = 2'b01; sel = 3'b010;
                m |= 32'hFFE0 & ~32'h00C0;
            end
            S_DECODE: begin sb = 2'b11; sel = 3'b010; m |= 32'hE700; end
            S_MEMADR: begin sa = 1'b1; sb = 2'b10; sel = 3'b010; m |= 32'hE700; end
            S_MEMRD:  begin mr = 1'b1; iod = 1'b1; sel = 3'b010; m |= 32'hE020; end
            S_MEM_WB: begin rw = 1'b1; m2r = 1'b1; m |= 32'h00C0; end
            S_MEMWR:  begin mw = 1'b1; iod = 1'b1; sel = 3'b010; m |= 32'hE020; end
            S_EXEC_R: begin
                fm = funct_map(fn);
                sa = 1'b1; sel = fm[2:0];
                m |= 32'h0700;
                if (fm[3]) m |= 32'hE000;
            end
            S_R_WB:   begin rw = 1'b1; rd = 1'b1; m |= 32'h00C0; end
            S_BRANCH: begin
                sa = 1'b1; sel = 3'b110; ps = 2'b01; pcw = zr;
                m |= 32'hFF00;
            end
            S_EXEC_I: begin
                sa = 1'b1; sb = 2'b10; sel = 3'b010;
`ifdef CTRL_IMM_LOGIC_EN
                if (op == 6'b001100) begin sel = 3'b000; zx = 1'b1; end
                if (op == 6'b001101) begin sel = 3'b001; zx = 1'b1; end
`endif
                m |= 32'hE700;
            end
            S_I_WB:   begin rw = 1'b1; m |= 32'h00C0; end
            S_JUMP:   begin ps = 2'b10; pcw = 1'b1; m |= 32'h1800; end
            default: ;
        endcase
        e = {9'b0, zx, st4, exp_timeout, exp_illegal, sel, ps, sb, sa, m2r, rd, iod, rw, mw, mr, irw, pcw};
    endtask

    task automatic do_cycle(input int st, input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                            input logic zr);
        logic [31:0] e, m, a;
        mem_ready = rdy;
        if (st == S_FETCH) begin
            opcode        = 6'($urandom);
            function_code = 6'($urandom);
        end else begin
            opcode        = op;
            function_code = fn;
        end
        zero = (st == S_BRANCH) ? zr : 1'($urandom);
        @(negedge clk);
        expect_word(st, opcode, function_code, rdy, zero, e, m);
        a = act_word();
        rec.push_back(a);
        check($sformatf("cycle state=%0d", st), a, e, m);
        @(posedge clk);
        if ((st == S_FETCH || st == S_MEMRD || st == S_MEMWR) && !rdy) begin
            if (wait_run < MAXW) wait_run++;
            if (wait_run == MAXW) exp_timeout = 1'b1;
        end else begin
            wait_run = 0;
        end
        if (st == S_DECODE && op_kind(op) == K_ILL) exp_illegal = 1'b1;
        if (st == S_EXEC_R && !funct_map(fn)[3]) exp_illegal = 1'b1;
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                             input int fwait, input int mwait);
        int k;
        k = op_kind(op);
        rec.delete();
        for (int i = 0; i < fwait; i++) do_cycle(S_FETCH, 1'b0, op, fn, zr);
        do_cycle(S_FETCH, 1'b1, op, fn, zr);
        do_cycle(S_DECODE, 1'($urandom), op, fn, zr);
        case (k)
            K_LW: begin
                do_cycle(S_MEMADR, 1'($urandom), op, fn, zr);
                for (int i = 0; i < mwait; i++) do_cycle(S_MEMRD, 1'b0, op, fn, zr);
                do_cycle(S_MEMRD, 1'b1, op, fn, zr);
                do_cycle(S_MEM_WB, 1'($urandom), op, fn, zr);
            end
            K_SW: begin
                do_cycle(S_MEMADR, 1'($urandom), op, fn, zr);
                for (int i = 0; i < mwait; i++) do_cycle(S_MEMWR, 1'b0, op, fn, zr);
                do_cycle(S_MEMWR, 1'b1, op, fn, zr);
            end
            K_R: begin
                do_cycle(S_EXEC_R, 1'($urandom), op, fn, zr);
                if (funct_map(fn)[3]) do_cycle(S_R_WB, 1'($urandom), op, fn, zr);
            end
            K_BEQ: do_cycle(S_BRANCH, 1'($urandom), op, fn, zr);
            K_ADDI, K_IMM: begin
                do_cycle(S_EXEC_I, 1'($urandom), op, fn, zr);
                do_cycle(S_I_WB, 1'($urandom), op, fn, zr);
            end
            K_J: do_cycle(S_JUMP, 1'($urandom), op, fn, zr);
            default: ;
        endcase
    endtask

    // nib holds the expected state of cycle i in nibble i (LSB first)
    task automatic check_seq(input string name, input int n, input logic [63:0] nib);
        check({name, " length"}, 32'(rec.size()), 32'(n), '1);
        for (int i = 0; i < n && i < rec.size(); i++)
            check($sformatf("%s seq[%0d]", name, i), {28'b0, rec[i][21:18]}, {28'b0, nib[i*4 +: 4]}, 32'hF);
        check({name, " back to FETCH"}, {28'b0, state}, 32'h0, 32'hF);
    endtask

    function automatic logic [5:0] rand_funct();
        case ($urandom_range(0, 5))
            0: return 6'b100000;
            1: return 6'b100010;
            2: return 6'b100100;
            3: return 6'b100101;
            4: return 6'b101010;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 9))
            0: return 6'b100011;
            1: return 6'b101011;
            2, 3: return 6'b000000;
            4: return 6'b000100;
            5: return 6'b001000;
            6: return 6'b000010;
            7: return 6'b001100;
            8: return 6'b001101;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        rst = 1'b1; opcode = '0; function_code = '0; zero = 1'b0; mem_ready = 1'b0;
        exp_illegal = 1'b0; exp_timeout = 1'b0; wait_run = 0;
        #2;
        check("reset state", act_word(), 32'h0, FULL_MASK);
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
        check_seq("lw wait3", 8, 64'h4333_3210);
        check("lw reg_write in MEM_WB", {31'b0, rec[7][4]}, 32'h1, 32'h1);
        check("lw no timeout", {31'b0, rec[7][17]}, 32'h0, 32'h1);

        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
        check_seq("rtype sub", 4, 64'h7610);
        check("rtype sub alu_sel", {29'b0, rec[2][15:13]}, 32'h6, 32'h7);
        check("rtype R_WB reg_write/reg_dst", {30'b0, rec[3][6], rec[3][4]}, 32'h3, 32'h3);

        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        check_seq("beq taken", 3, 64'h810);
        check("beq taken pc_write/pc_src", {29'b0, rec[2][12:11], rec[2][0]}, 32'h3, 32'h7);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        check("beq not taken pc_write", {31'b0, rec[2][0]}, 32'h0, 32'h1);

        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
        check_seq("jump", 3, 64'hB10);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 0);
        check_seq("sw", 4, 64'h5210);
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
        check_seq("addi", 4, 64'hA910);

        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        check_seq("illegal op", 2, 64'h10);
        check("illegal no writes", {30'b0, rec[1][4], rec[1][3]}, 32'h0, 32'h3);
        check("illegal flag set", {31'b0, illegal_op}, 32'h1, 32'h1);
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
        check("illegal flag sticky", {31'b0, illegal_op}, 32'h1, 32'h1);

        run_instr(6'b000010, 6'b000000, 1'b0, 20, 0);
        check("timeout low after 14 waits", {31'b0, rec[14][17]}, 32'h0, 32'h1);
        check("timeout high after 15 waits", {31'b0, rec[15][17]}, 32'h1, 32'h1);
        check("timeout held at 19 waits", {31'b0, rec[19][17]}, 32'h1, 32'h1);
        check("fetch exits to DECODE", {28'b0, rec[21][21:18]}, 32'h1, 32'hF);
        check("timeout sticky", {31'b0, mem_timeout}, 32'h1, 32'h1);

        rec.delete();
        do_cycle(S_FETCH, 1'b1, 6'b100011, 6'b0, 1'b0);
        do_cycle(S_DECODE, 1'b0, 6'b100011, 6'b0, 1'b0);
        do_cycle(S_MEMADR, 1'b0, 6'b100011, 6'b0, 1'b0);
        do_cycle(S_MEMRD, 1'b0, 6'b100011, 6'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        a = act_word();
        check("async reset mid-MEMRD", a, 32'h0, FULL_MASK);
        exp_illegal = 1'b0; exp_timeout = 1'b0; wait_run = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int n = 0; n < 80; n++) begin
            int fw, mw;
            fw = ($urandom_range(0, 19) == 0) ? 16 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 19) == 0) ? 16 : int'($urandom_range(0, 3));
            run_instr(rand_op(), rand_funct(), 1'($urandom), fw, mw);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
